// File: rtl/hls_deadlock_pkg.sv
// Shared FSM state type and counter width for the deadlock report scheduler.
package hls_deadlock_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } rpt_state_t;

endpackage

// File: rtl/hls_deadlock_persist_cnt.sv
// Per-monitor persistence counter: confirms a deadlock after PERSIST consecutive
// block cycles and latches the timestamp of the confirming cycle.
module hls_deadlock_persist_cnt
  import hls_deadlock_pkg::*;
#(
  parameter int PERSIST = 16,
  parameter int TS_W    = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            block,
  input  logic [TS_W-1:0] ts_now,
  output logic            confirmed,
  output logic            confirm_pulse,
  output logic [TS_W-1:0] ts
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERSIST - 1);

  logic [CNT_W-1:0] cnt;

  // Fires only on the edge where the count moves into PERSIST, never while saturated.
  assign confirm_pulse = enable && block && (cnt == LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      confirmed <= 1'b0;
      ts        <= '0;
    end else if (!enable || !block) begin
      cnt       <= '0;
      confirmed <= 1'b0;
    end else begin
      if (cnt != LIMIT) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (confirm_pulse) begin
        confirmed <= 1'b1;
        ts        <= ts_now;
      end
    end
  end

endmodule

// File: rtl/hls_deadlock_report_scheduler.sv
// Collects confirmed deadlocks from N_MON monitors and offers them one at a time
// over a valid/ready report channel with round-robin fairness.
module hls_deadlock_report_scheduler
  import hls_deadlock_pkg::*;
#(
  parameter  int N_MON   = 4,
  parameter  int PERSIST = 16,
  parameter  int TS_W    = 32,
  localparam int ID_W    = $clog2(N_MON)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_MON-1:0] mon_block,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [ID_W-1:0]  rpt_id,
  output logic [TS_W-1:0]  rpt_ts,
  output logic             deadlock_any
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_MON - 1);

  rpt_state_t       state_q;
  rpt_state_t       state_d;
  logic [TS_W-1:0]  timestamp;
  logic [TS_W-1:0]  ts_latched [N_MON];
  logic [N_MON-1:0] confirmed;
  logic [N_MON-1:0] confirm_pulse;
  logic [N_MON-1:0] pending;
  logic [N_MON-1:0] reported;
  logic [N_MON-1:0] hs_vec;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  cand;
  logic             found;
  logic             handshake;

  assign rpt_valid = (state_q == SEND);
  assign handshake = rpt_valid && rpt_ready;

  // The confirming cycle's timestamp is the value the counter takes after this edge.
  for (genvar g = 0; g < N_MON; g++) begin : g_mon
    hls_deadlock_persist_cnt #(
      .PERSIST (PERSIST),
      .TS_W    (TS_W)
    ) u_persist (
      .clock         (clock),
      .reset         (reset),
      .enable        (enable),
      .block         (mon_block[g]),
      .ts_now        (timestamp + TS_W'(1)),
      .confirmed     (confirmed[g]),
      .confirm_pulse (confirm_pulse[g]),
      .ts            (ts_latched[g])
    );
  end

  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N_MON; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % N_MON);
      if (!found && pending[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    hs_vec = '0;
    if (handshake) begin
      hs_vec[rpt_id] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable && (|pending)) state_d = SEND;
      SEND:    if (!enable || rpt_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rpt_id       <= '0;
      rpt_ts       <= '0;
      rr_ptr       <= '0;
      timestamp    <= '0;
      deadlock_any <= 1'b0;
    end else begin
      state_q      <= state_d;
      timestamp    <= timestamp + TS_W'(1);
      deadlock_any <= |confirmed;
      if (state_q == IDLE && state_d == SEND) begin
        rpt_id <= winner;
        rpt_ts <= ts_latched[winner];
      end
      if (handshake) begin
        rr_ptr <= (rpt_id == LAST_ID) ? '0 : rpt_id + ID_W'(1);
      end
    end
  end

  // Handshake beats a same-cycle confirmation; a dropped monitor beats a handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending  <= '0;
      reported <= '0;
    end else if (!enable) begin
      pending  <= '0;
      reported <= '0;
    end else begin
      for (int i = 0; i < N_MON; i++) begin
        if (hs_vec[i]) begin
          pending[i] <= 1'b0;
        end else if (confirm_pulse[i] && !reported[i]) begin
          pending[i] <= 1'b1;
        end
        if (!mon_block[i]) begin
          reported[i] <= 1'b0;
        end else if (hs_vec[i]) begin
          reported[i] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hls_deadlock_report_scheduler.sv
// Scoreboard bench: a run-length reference model predicts every report and the
// negedge monitor compares each DUT handshake and cycle state against it.
module tb_hls_deadlock_report_scheduler;

  localparam int N_MON   = 4;
  localparam int PERSIST = 16;
  localparam int TS_W    = 32;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [N_MON-1:0] mon_block;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [1:0]       rpt_id;
  logic [TS_W-1:0]  rpt_ts;
  logic             deadlock_any;

  hls_deadlock_report_scheduler #(
    .N_MON   (N_MON),
    .PERSIST (PERSIST),
    .TS_W    (TS_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .mon_block    (mon_block),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .rpt_id       (rpt_id),
    .rpt_ts       (rpt_ts),
    .deadlock_any (deadlock_any)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] ts;
  } rpt_t;

  rpt_t exp_q [$];
  int   hs_log [$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state: consecutive-block run lengths and report episodes.
  int          m_run [N_MON];
  bit          m_conf [N_MON];
  bit          m_pend [N_MON];
  bit          m_rep [N_MON];
  logic [31:0] m_conf_ts [N_MON];
  bit          m_busy;
  bit          m_any;
  int          m_cur_id;
  logic [31:0] m_cur_ts;
  int          m_rr;
  logic [31:0] m_ts;
  int          cyc;
  bit          m_hs;
  bit          m_newly;
  bit          m_any_conf;
  int          m_pick;
  int          m_idx;
  int          m_hs_id;

  bit          hs_seen;
  logic [31:0] hs_id_obs;
  logic [31:0] hs_ts_obs;
  rpt_t        popped;
  int          first_cyc;
  logic [31:0] seen_id;
  logic [31:0] seen_ts;
  logic        seen_any;
  logic [3:0]  rb;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  initial begin
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        for (int i = 0; i < N_MON; i++) begin
          m_run[i] = 0; m_conf[i] = 0; m_pend[i] = 0; m_rep[i] = 0; m_conf_ts[i] = '0;
        end
        m_busy = 0; m_any = 0; m_cur_id = 0; m_cur_ts = '0; m_rr = 0; m_ts = '0; cyc = 0;
      end else begin
        m_hs    = m_busy && rpt_ready;
        m_hs_id = m_hs ? m_cur_id : -1;
        m_any_conf = 0;
        for (int i = 0; i < N_MON; i++) m_any_conf |= m_conf[i];
        m_pick = -1;
        for (int k = 0; k < N_MON; k++) begin
          m_idx = (m_rr + k) % N_MON;
          if (m_pick < 0 && m_pend[m_idx]) m_pick = m_idx;
        end
        if (m_hs) begin
          exp_q.push_back({32'(m_cur_id), m_cur_ts});
          m_rr = (m_cur_id + 1) % N_MON;
        end
        if (!enable) m_busy = 0;
        else if (m_busy) m_busy = !rpt_ready;
        else if (m_pick >= 0) begin
          m_busy = 1; m_cur_id = m_pick; m_cur_ts = m_conf_ts[m_pick];
        end
        for (int i = 0; i < N_MON; i++) begin
          if (!enable) begin
            m_run[i] = 0; m_conf[i] = 0; m_pend[i] = 0; m_rep[i] = 0;
          end else begin
            m_run[i]  = mon_block[i] ? m_run[i] + 1 : 0;
            m_newly   = (m_run[i] == PERSIST);
            m_conf[i] = (m_run[i] >= PERSIST);
            if (m_newly) m_conf_ts[i] = m_ts + 32'd1;
            if (m_hs_id == i) m_pend[i] = 0;
            else if (m_newly && !m_rep[i]) m_pend[i] = 1;
            m_rep[i] = mon_block[i] && (m_rep[i] || (m_hs_id == i));
          end
        end
        m_any = m_any_conf;
        m_ts  = m_ts + 32'd1;
        cyc++;
      end
    end
  end

  initial begin
    hs_seen = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        hs_seen = 0;
      end else begin
        if (hs_seen) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard: got report id %0d, expected none", hs_id_obs);
          end else begin
            popped = exp_q.pop_front();
            check_output("sb rpt_id", hs_id_obs, popped.id);
            check_output("sb rpt_ts", hs_ts_obs, popped.ts);
          end
        end
        hs_seen   = rpt_valid && rpt_ready;
        hs_id_obs = 32'(rpt_id);
        hs_ts_obs = rpt_ts;
        if (hs_seen) hs_log.push_back(int'(rpt_id));
        check_output("rpt_valid", 32'(rpt_valid), 32'(m_busy));
        check_output("deadlock_any", 32'(deadlock_any), 32'(m_any));
        if (m_busy) begin
          check_output("rpt_id", 32'(rpt_id), 32'(m_cur_id));
          check_output("rpt_ts", rpt_ts, m_cur_ts);
        end
      end
    end
  end

  task automatic apply_stimulus(input bit en, input logic [3:0] blk, input bit rdy,
                                input int n);
    enable    = en;
    mon_block = blk;
    rpt_ready = rdy;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rpt_ready = 1'b0;
    enable    = 1'b1;
    mon_block = '0;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_output("reset rpt_valid", 32'(rpt_valid), 32'd0);
    check_output("reset rpt_id", 32'(rpt_id), 32'd0);
    check_output("reset rpt_ts", rpt_ts, 32'd0);
    check_output("reset deadlock_any", 32'(deadlock_any), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, input string name);
    int c;
    c = 0;
    do begin
      @(negedge clock);
      c++;
    end while (!rpt_valid && c < max_cycles);
    check_output({name, " timeout"}, 32'(rpt_valid), 32'd1);
    first_cyc = cyc;
    seen_id   = 32'(rpt_id);
    seen_ts   = rpt_ts;
    seen_any  = deadlock_any;
    @(posedge clock);
    #1;
  endtask

  initial begin
    $display("[TB] start");
    reset     = 1'b0;
    enable    = 1'b1;
    mon_block = '0;
    rpt_ready = 1'b0;

    // Single monitor latency and timestamp
    do_reset();
    apply_stimulus(1, 4'b0000, 1, 10);
    hs_log.delete();
    mon_block = 4'b0100;
    rpt_ready = 1'b1;
    wait_valid(40, "first report");
    check_output("first valid cycle", 32'(first_cyc), 32'd27);
    check_output("first rpt_id", seen_id, 32'd2);
    check_output("first rpt_ts", seen_ts, 32'd26);
    check_output("first deadlock_any", 32'(seen_any), 32'd1);
    apply_stimulus(1, 4'b0100, 1, 30);
    check_output("held monitor report count", 32'(hs_log.size()), 32'd1);

    // Interrupted run must restart persistence
    apply_stimulus(1, 4'b0000, 1, 3);
    hs_log.delete();
    apply_stimulus(1, 4'b0010, 1, 15);
    apply_stimulus(1, 4'b0000, 1, 1);
    apply_stimulus(1, 4'b0010, 1, 16);
    check_output("no early report count", 32'(hs_log.size()), 32'd0);
    check_output("no early rpt_valid", 32'(rpt_valid), 32'd0);
    apply_stimulus(1, 4'b0010, 1, 3);
    check_output("rerise report count", 32'(hs_log.size()), 32'd1);
    if (hs_log.size() == 1) check_output("rerise report id", 32'(hs_log[0]), 32'd1);

    // Simultaneous confirmations served round-robin
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      hs_log.delete();
      apply_stimulus(1, 4'b1011, 1, 30);
      check_output("rr report count", 32'(hs_log.size()), 32'd3);
      if (hs_log.size() == 3) begin
        check_output("rr order 0", 32'(hs_log[0]), 32'd0);
        check_output("rr order 1", 32'(hs_log[1]), 32'd1);
        check_output("rr order 2", 32'(hs_log[2]), 32'd3);
      end
      apply_stimulus(1, 4'b0000, 1, 2);
    end

    // Backpressure while the monitor deasserts
    hs_log.delete();
    enable    = 1'b1;
    rpt_ready = 1'b0;
    mon_block = 4'b0100;
    wait_valid(40, "stall report");
    apply_stimulus(1, 4'b0000, 0, 20);
    check_output("stall rpt_valid", 32'(rpt_valid), 32'd1);
    check_output("stall rpt_id", 32'(rpt_id), 32'd2);
    check_output("stall no handshake", 32'(hs_log.size()), 32'd0);
    apply_stimulus(1, 4'b0000, 1, 3);
    check_output("stall delivered", 32'(hs_log.size()), 32'd1);
    check_output("stall deadlock_any dropped", 32'(deadlock_any), 32'd0);

    // No duplicate while held; one new report after re-confirmation
    apply_stimulus(1, 4'b0000, 1, 2);
    hs_log.delete();
    apply_stimulus(1, 4'b0001, 1, 50);
    check_output("held report count", 32'(hs_log.size()), 32'd1);
    apply_stimulus(1, 4'b0000, 1, 1);
    apply_stimulus(1, 4'b0001, 1, 30);
    check_output("reconfirm report count", 32'(hs_log.size()), 32'd2);

    // Reset during SEND, then enable pulse low during SEND
    do_reset();
    rpt_ready = 1'b0;
    mon_block = 4'b0001;
    wait_valid(40, "pre-reset report");
    #2;
    reset = 1'b0;
    #1;
    check_output("async rpt_valid", 32'(rpt_valid), 32'd0);
    check_output("async rpt_id", 32'(rpt_id), 32'd0);
    check_output("async rpt_ts", rpt_ts, 32'd0);
    check_output("async deadlock_any", 32'(deadlock_any), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    hs_log.delete();
    apply_stimulus(1, 4'b0001, 0, 10);
    check_output("post-reset no reoffer", 32'(rpt_valid), 32'd0);
    wait_valid(30, "reconfirm after reset");
    apply_stimulus(0, 4'b0001, 0, 1);
    check_output("enable low rpt_valid", 32'(rpt_valid), 32'd0);
    apply_stimulus(1, 4'b0001, 0, 5);
    check_output("pending cleared rpt_valid", 32'(rpt_valid), 32'd0);
    check_output("no handshake before ready", 32'(hs_log.size()), 32'd0);
    apply_stimulus(1, 4'b0001, 1, 25);
    check_output("post-enable report count", 32'(hs_log.size()), 32'd1);

    // Randomized traffic against the model
    apply_stimulus(1, 4'b0000, 1, 2);
    rb = 4'b0000;
    for (int c = 0; c < 500; c++) begin
      for (int b = 0; b < N_MON; b++) begin
        if ($urandom_range(0, 19) == 0) rb[b] = ~rb[b];
      end
      apply_stimulus($urandom_range(0, 79) != 0, rb, $urandom_range(0, 3) != 0, 1);
    end
    apply_stimulus(1, 4'b0000, 1, 25);
    apply_stimulus(1, 4'b0000, 0, 2);
    check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
